// File: rtl/wave_bank_sequencer.sv
// Per-channel parameter shadow registers, atomic frame-aligned commit to the
// live buses, and programmable per-channel tick dividers re-aligned on commit.
module wave_bank_sequencer #(
    parameter int NCH  = 8,
    parameter int DIVW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_chan,
    input  logic [1:0]        cmd_field,
    input  logic [15:0]       cmd_data,
    input  logic              commit_req,
    input  logic              sample_tick,
    output logic [NCH*16-1:0] amps,
    output logic [NCH*16-1:0] offsets,
    output logic [NCH*16-1:0] phasewords,
    output logic [NCH-1:0]    clks,
    output logic              commit_pending,
    output logic              commit_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    state_t          state_q;
    logic            commit_pending_q;
    logic            commit_done_q;

    logic [15:0]     sh_amp_q [NCH];
    logic [15:0]     sh_off_q [NCH];
    logic [15:0]     sh_phw_q [NCH];
    logic [DIVW-1:0] sh_div_q [NCH];

    logic [15:0]     lv_amp_q [NCH];
    logic [15:0]     lv_off_q [NCH];
    logic [15:0]     lv_phw_q [NCH];
    logic [DIVW-1:0] lv_div_q [NCH];

    logic cmd_fire;
    logic apply_en;

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign apply_en  = (state_q == ST_PENDING) && sample_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            commit_pending_q <= 1'b0;
            commit_done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    commit_done_q <= 1'b0;
                    if (commit_req) begin
                        state_q          <= ST_PENDING;
                        commit_pending_q <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (sample_tick) begin
                        state_q          <= ST_APPLY;
                        commit_pending_q <= 1'b0;
                        commit_done_q    <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    state_q       <= ST_IDLE;
                    commit_done_q <= 1'b0;
                end
                default: begin
                    state_q          <= ST_IDLE;
                    commit_pending_q <= 1'b0;
                    commit_done_q    <= 1'b0;
                end
            endcase
        end
    end

    // Shadow writes are only accepted in IDLE, so they never race a commit copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                sh_amp_q[i] <= '0;
                sh_off_q[i] <= '0;
                sh_phw_q[i] <= '0;
                sh_div_q[i] <= '0;
            end
        end else if (cmd_fire) begin
            case (cmd_field)
                2'b00:   sh_amp_q[cmd_chan] <= cmd_data;
                2'b01:   sh_off_q[cmd_chan] <= cmd_data;
                2'b10:   sh_phw_q[cmd_chan] <= cmd_data;
                default: sh_div_q[cmd_chan] <= cmd_data[DIVW-1:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                lv_amp_q[i] <= '0;
                lv_off_q[i] <= '0;
                lv_phw_q[i] <= '0;
                lv_div_q[i] <= '0;
            end
        end else if (apply_en) begin
            for (int i = 0; i < NCH; i++) begin
                lv_amp_q[i] <= sh_amp_q[i];
                lv_off_q[i] <= sh_off_q[i];
                lv_phw_q[i] <= sh_phw_q[i];
                lv_div_q[i] <= sh_div_q[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [DIVW-1:0] cnt_q;
            logic [DIVW-1:0] cnt_d;
            logic            tick_q;

            // The strobe is high in the same cycle the counter reads div.
            always_comb begin
                cnt_d = (cnt_q == lv_div_q[gi]) ? '0 : cnt_q + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (reset || state_q == ST_APPLY || lv_div_q[gi] == '0) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    tick_q <= (cnt_d == lv_div_q[gi]);
                end
            end

            assign amps[16*gi +: 16]       = lv_amp_q[gi];
            assign offsets[16*gi +: 16]    = lv_off_q[gi];
            assign phasewords[16*gi +: 16] = lv_phw_q[gi];
            assign clks[gi]                = tick_q;
        end
    endgenerate

    assign commit_pending = commit_pending_q;
    assign commit_done    = commit_done_q;

endmodule

// File: tb/tb_wave_bank_sequencer.sv
// Scoreboarded bench for wave_bank_sequencer: expected live buses are queued
// when a commit is triggered and compared when commit_done appears.
module tb_wave_bank_sequencer;

    localparam int NCH = 8;

    logic           clk;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_chan;
    logic [1:0]     cmd_field;
    logic [15:0]    cmd_data;
    logic           commit_req;
    logic           sample_tick;
    logic [127:0]   amps;
    logic [127:0]   offsets;
    logic [127:0]   phasewords;
    logic [7:0]     clks;
    logic           commit_pending;
    logic           commit_done;

    wave_bank_sequencer #(.NCH(NCH), .DIVW(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_chan       (cmd_chan),
        .cmd_field      (cmd_field),
        .cmd_data       (cmd_data),
        .commit_req     (commit_req),
        .sample_tick    (sample_tick),
        .amps           (amps),
        .offsets        (offsets),
        .phasewords     (phasewords),
        .clks           (clks),
        .commit_pending (commit_pending),
        .commit_done    (commit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] amps;
        logic [127:0] offsets;
        logic [127:0] phasewords;
    } live_set_t;

    live_set_t   sb_q[$];
    logic [15:0] m_sh [4][NCH];
    int          checks;
    int          errors;
    int          done_cnt;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (commit_done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_done", 1, 0);
            end else begin
                live_set_t e;
                e = sb_q.pop_front();
                check_eq("sb_amps", amps, e.amps);
                check_eq("sb_offsets", offsets, e.offsets);
                check_eq("sb_phasewords", phasewords, e.phasewords);
                $display("commit %0d live: amps=%h offsets=%h phasewords=%h",
                         done_cnt, amps, offsets, phasewords);
            end
        end
    end

    task automatic clear_model();
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < NCH; c++)
                m_sh[f][c] = 16'h0;
    endtask

    task automatic write_cmd(input int chan, input int field, input logic [15:0] data,
                             input logic with_commit);
        check_eq("wr_ready", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_chan   = chan[2:0];
        cmd_field  = field[1:0];
        cmd_data   = data;
        commit_req = with_commit;
        @(negedge clk);
        cmd_valid  = 1'b0;
        commit_req = 1'b0;
        m_sh[field][chan] = data;
        $display("write chan=%0d field=%0d data=%h commit=%0b", chan, field, data, with_commit);
        if (with_commit) check_eq("wr_commit_pending", commit_pending, 1);
    endtask

    task automatic request_commit();
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        check_eq("req_pending", commit_pending, 1);
        check_eq("req_ready_low", cmd_ready, 0);
    endtask

    task automatic apply_commit(input int gap);
        live_set_t e;
        repeat (gap) begin
            @(negedge clk);
            check_eq("pend_ready_low", cmd_ready, 0);
            check_eq("pend_pending", commit_pending, 1);
        end
        for (int c = 0; c < NCH; c++) begin
            e.amps[16*c +: 16]       = m_sh[0][c];
            e.offsets[16*c +: 16]    = m_sh[1][c];
            e.phasewords[16*c +: 16] = m_sh[2][c];
        end
        sb_q.push_back(e);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check_eq("apply_done", commit_done, 1);
        check_eq("apply_pending_clr", commit_pending, 0);
    endtask

    initial begin
        int d0;
        checks = 0; errors = 0; done_cnt = 0;
        clear_model();
        reset = 1'b1; cmd_valid = 1'b1; cmd_chan = '0; cmd_field = '0; cmd_data = '0;
        commit_req = 1'b0; sample_tick = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", cmd_ready, 0);
        check_eq("rst_amps", amps, 0);
        check_eq("rst_offsets", offsets, 0);
        check_eq("rst_phasewords", phasewords, 0);
        check_eq("rst_clks", clks, 0);
        check_eq("rst_pending", commit_pending, 0);
        check_eq("rst_done", commit_done, 0);
        reset = 1'b0; cmd_valid = 1'b0;
        #1;
        check_eq("rel_ready", cmd_ready, 1);
        @(negedge clk);

        // Shadow writes must not disturb the live bus until a commit applies.
        write_cmd(3, 0, 16'h8000, 1'b0);
        check_eq("wr_amps_live0", amps, 0);
        write_cmd(3, 2, 16'h0100, 1'b0);
        check_eq("wr_phw_live0", phasewords, 0);
        request_commit();
        apply_commit(4);
        check_eq("c1_amp3", amps[63:48], 16'h8000);
        check_eq("c1_phw3", phasewords[63:48], 16'h0100);
        @(negedge clk);
        check_eq("c1_done_one_cycle", commit_done, 0);
        check_eq("c1_ready_back", cmd_ready, 1);

        // Write and commit request in the same cycle.
        write_cmd(0, 1, 16'h1234, 1'b1);
        apply_commit(2);
        check_eq("c2_off0", offsets[15:0], 16'h1234);
        @(negedge clk);

        // Divider alignment.
        write_cmd(0, 3, 16'd3, 1'b0);
        write_cmd(7, 3, 16'd3, 1'b0);
        write_cmd(5, 3, 16'd0, 1'b0);
        request_commit();
        apply_commit(1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check_eq($sformatf("div_clks_k%0d", k), clks, (k % 4 == 0) ? 8'h81 : 8'h00);
        end

        // A second commit_req while pending is ignored.
        d0 = done_cnt;
        commit_req = 1'b1;
        @(negedge clk);
        check_eq("ign_pending", commit_pending, 1);
        @(negedge clk);
        commit_req = 1'b0;
        apply_commit(1);
        repeat (4) @(negedge clk);
        check_eq("ign_one_done", done_cnt - d0, 1);
        check_eq("ign_idle", commit_pending, 0);

        // Reset while pending discards the commit and clears live state.
        write_cmd(1, 0, 16'h5555, 1'b0);
        request_commit();
        reset = 1'b1;
        @(negedge clk);
        check_eq("rp_ready", cmd_ready, 0);
        reset = 1'b0;
        clear_model();
        check_eq("rp_amps", amps, 0);
        check_eq("rp_offsets", offsets, 0);
        check_eq("rp_phw", phasewords, 0);
        check_eq("rp_pending", commit_pending, 0);
        d0 = done_cnt;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rp_no_done", done_cnt - d0, 0);
        check_eq("rp_amps_after", amps, 0);
        check_eq("rp_offsets_after", offsets, 0);
        check_eq("rp_clks", clks, 0);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
